mem_req_master: RTL and testbench
=================================

Name: mem_req_master

Overview:
- Initiator-side controller for the team's 16x8 synchronous RAM (ports wr_enb/rd_enb/wr_addr/rd_addr/wr_data/rd_data).
- Accepts write and read requests on a valid/ready request channel and drives the RAM-side pins with registered outputs.
- Captures read data after the RAM's read latency and returns it on a valid/ready response channel.
- Sits between a producer (bench driver or upstream logic) and the RAM.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 16, number of RAM words; equals 2**ADDR_W.
- RD_LAT, 1, number of clock edges from the RAM sampling rd_enb until rd_data is valid; range 1..3.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  address the response belongs to.
- busy  out  1  controller is not idle or a RAM write is in flight.
- wr_enb  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  DATA_W  RAM write data.
- rd_enb  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data.

Behaviour:
- Reset (rst=0, asynchronous): every output register is cleared: wr_enb, rd_enb, wr_addr, wr_data, rd_addr, rsp_valid, rsp_rdata and rsp_addr all 0. FSM goes to IDLE (to CLEAR when the macro is defined). Latency counter goes to 0.
- Reset mid-operation drops any outstanding read and any pending response, with no partial effects afterwards.
- FSM states: IDLE, RD_WAIT, RSP (plus CLEAR when the macro is defined).
- req_ready = (state==IDLE), combinational from the state register only. It never depends on req_valid.
- Handshake: a transfer occurs at the edge where req_valid && req_ready. The request is stable until accepted.
- Write accepted at edge N:
  - wr_enb=1 with wr_addr/wr_data loaded during cycle N..N+1; the RAM commits at edge N+1.
  - wr_enb returns to 0 unless another write is accepted at edge N+1.
  - State stays IDLE, so back-to-back writes run at 1 per cycle. No response is generated.
- Read accepted at edge N:
  - rd_enb=1 and rd_addr loaded for exactly one cycle.
  - State goes to RD_WAIT; the counter loads RD_LAT.
  - At edge N+1+RD_LAT the controller captures rd_data into rsp_rdata, sets rsp_valid=1 and rsp_addr=the request address, and moves to RSP.
  - Minimum acceptance-to-rsp_valid latency is 2 cycles (RD_LAT=1).
- RSP:
  - rsp_valid, rsp_rdata and rsp_addr stay stable until rsp_ready=1.
  - At the handshake edge rsp_valid drops to 0 and the state returns to IDLE.
  - The next request can be accepted at the following edge; at most one read is outstanding.
- Ordering: a read accepted the cycle after a write to the same address returns the new data, because the write commits one edge before rd_enb is sampled.
- wr_enb and rd_enb are never both 1 in the same cycle.
- Address arithmetic (CLEAR counter) is ADDR_W bits and wraps from DEPTH-1 to 0.
- busy = (state!=IDLE) || wr_enb.

Optional Feature:
- MEM_CLR_ON_RESET_EN defined:
  - On leaving reset the FSM enters CLEAR and drives wr_enb=1, wr_data=0, wr_addr=0,1,…,DEPTH-1, one address per cycle.
  - req_ready=0 and busy=1 throughout CLEAR.
  - After address DEPTH-1 is written, the FSM goes to IDLE. The first request is accepted DEPTH+1 edges after rst deasserts.
- Undefined: the FSM starts in IDLE and req_ready=1 in the first cycle after rst deasserts. RAM contents are untouched.

Decomposition:
- Shared package (alongside the existing memory bench package) holds:
  - ADDR_W/DATA_W/DEPTH/RD_LAT defaults.
  - typedef enum mem_ms_state_e {IDLE, RD_WAIT, RSP, CLEAR}.
  - typedef struct mem_req_t {wr, addr, wdata}.
- Single module, no sub-module. The CLEAR sweep counter and RD_LAT counter are inline.

Test Plan:
- Write addr 3 data 8'hA5, then read addr 3 the next cycle -> wr_enb pulses 1 cycle; rsp_valid 2 cycles after read acceptance with rsp_rdata=8'hA5, rsp_addr=3.
- Writes to addr 0..15 data=addr*17 on consecutive cycles -> req_ready stays 1, 16 wr_enb pulses. Then reads 0..15 -> each rsp_rdata = addr*17 in order.
- Read addr 7 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0. rsp_ready=1 -> rsp_valid drops; next request accepted the following edge.
- Assert rst low while in RD_WAIT -> all outputs 0 immediately; no rsp_valid appears after release.
- Macro defined: release rst, then read addr 9 (previously 8'hFF) -> busy for 16 cycles with wr_data=0; rsp_rdata=8'h00.
- RD_LAT=3 build: read addr 2 -> rsp_valid exactly 4 cycles after acceptance; rd_enb high exactly 1 cycle.

Source files
------------

// File: rtl/mem_req_master_pkg.sv
// ============================================================================
// mem_req_master_pkg : shared defaults and types for the RAM request master
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_req_master_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2,
    CLEAR   = 2'd3
  } mem_ms_state_e;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_master.sv
// ============================================================================
// mem_req_master : valid/ready initiator for the 16x8 synchronous RAM.
// Optional MEM_CLR_ON_RESET_EN zero-fills the RAM after reset. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_req_master
  import mem_req_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic              wr_enb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_RD_WAIT = RD_WAIT;
  localparam logic [1:0] S_RSP     = RSP;
  localparam logic [1:0] LAT_LOAD  = 2'(RD_LAT);

  if (DEPTH != (1 << ADDR_W) || RD_LAT < 1 || RD_LAT > 3) begin : g_bad_cfg
    $error("mem_req_master: DEPTH must be 2**ADDR_W and RD_LAT in 1..3");
  end

`ifdef MEM_CLR_ON_RESET_EN
  localparam logic [1:0] S_CLEAR   = CLEAR;
  localparam logic [1:0] RST_STATE = S_CLEAR;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`else
  localparam logic [1:0] RST_STATE = S_IDLE;
`endif

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_enb_q, wr_enb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_enb_q, rd_enb_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_enb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_enb_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
`ifdef MEM_CLR_ON_RESET_EN
    clr_addr_d  = clr_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_wr) begin
            wr_enb_d  = 1'b1;
            wr_addr_d = req_addr;
            wr_data_d = req_wdata;
          end else begin
            rd_enb_d  = 1'b1;
            rd_addr_d = req_addr;
            cnt_d     = LAT_LOAD;
            state_d   = S_RD_WAIT;
          end
        end
      end
      // cnt_q reaches 0 exactly on the edge where rd_data has become valid
      S_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_data;
          rsp_addr_d  = rd_addr_q;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef MEM_CLR_ON_RESET_EN
      S_CLEAR: begin
        wr_enb_d   = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= 2'd0;
      wr_enb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_enb_q    <= 1'b0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
`ifdef MEM_CLR_ON_RESET_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_enb_q    <= wr_enb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_enb_q    <= rd_enb_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
`ifdef MEM_CLR_ON_RESET_EN
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE) || wr_enb_q;
  assign wr_enb    = wr_enb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_enb    = rd_enb_q;
  assign rd_addr   = rd_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_addr  = rsp_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_master.sv
// ============================================================================
// tb_mem_req_master : self-checking bench with RAM model and reference memory
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_req_master;
  import mem_req_master_pkg::*;

  parameter int RD_LAT = DEF_RD_LAT;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DATA_W = DEF_DATA_W;
  localparam int DEPTH  = DEF_DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wr = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic              busy;
  logic              wr_enb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  always #5 clk = ~clk;

  mem_req_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_addr(rsp_addr), .busy(busy),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Behavioural RAM: write on the sampling edge, read data delayed RD_LAT edges
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'hFF;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  end
  always @(posedge clk) begin
    if (wr_enb) ram[wr_addr] <= wr_data;
    if (rd_enb) rd_pipe[0] <= ram[rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  // Reference model: expected RAM contents after each accepted write
  logic [DATA_W-1:0] ref_mem [DEPTH];

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  typedef struct {
    mem_req_t           req;
    int                 stall;
    logic [DATA_W-1:0]  exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_enb) wr_pulses++;
    if (rd_enb) rd_pulses++;
    chk("enb_exclusive", 32'(wr_enb && rd_enb), 32'd0);
    chk("busy", 32'(busy), 32'(!req_ready || wr_enb));
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, output int waited);
    waited = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    while (!req_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_wr = 1'b0;
    if (wr) begin
      ref_mem[a] = d;
      chk("wr_pins", {wr_enb, rd_enb, wr_addr, wr_data}, {1'b1, 1'b0, a, d});
    end else begin
      chk("rd_pins", {rd_enb, wr_enb, rd_addr}, {1'b1, 1'b0, a});
    end
  endtask

  task automatic recv(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input int stall);
    int lat = 0;
    rsp_ready = 1'b0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(RD_LAT + 1));
    chk("rsp_data", {rsp_valid, rsp_addr, rsp_rdata}, {1'b1, a, d});
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("rsp_hold", {rsp_valid, req_ready, rsp_addr, rsp_rdata}, {1'b1, 1'b0, a, d});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", {rsp_valid, req_ready}, {1'b0, 1'b1});
  endtask

  task automatic check_reset_outs(input string name);
    chk(name, {wr_enb, rd_enb, wr_addr, wr_data, rd_addr, rsp_valid, rsp_rdata, rsp_addr}, 32'd0);
  endtask

  // Called half a cycle after rst_n rises
  task automatic after_reset();
`ifdef MEM_CLR_ON_RESET_EN
    int n = 0;
    chk("clr_start", {req_ready, busy}, {1'b0, 1'b1});
    while (!req_ready && n < 40) begin
      tick();
      n++;
      chk("clr_write", {wr_enb, wr_addr, wr_data}, {1'b1, 4'(n - 1), 8'h00});
    end
    chk("clr_length", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    chk("ready_after_rst", {req_ready, busy}, {1'b1, 1'b0});
`endif
  endtask

  initial begin
    int w;
    int base;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
    vecs[0] = '{req: '{wr: 1'b1, addr: 4'd3,  wdata: 8'hA5}, stall: 0, exp: 8'h00};
    vecs[1] = '{req: '{wr: 1'b0, addr: 4'd3,  wdata: 8'h00}, stall: 0, exp: 8'hA5};
    vecs[2] = '{req: '{wr: 1'b1, addr: 4'd9,  wdata: 8'hFF}, stall: 0, exp: 8'h00};
    vecs[3] = '{req: '{wr: 1'b1, addr: 4'd7,  wdata: 8'h3C}, stall: 0, exp: 8'h00};
    vecs[4] = '{req: '{wr: 1'b0, addr: 4'd7,  wdata: 8'h00}, stall: 5, exp: 8'h3C};
    vecs[5] = '{req: '{wr: 1'b0, addr: 4'd9,  wdata: 8'h00}, stall: 1, exp: 8'hFF};
    vecs[6] = '{req: '{wr: 1'b1, addr: 4'd15, wdata: 8'h5A}, stall: 0, exp: 8'h00};
    vecs[7] = '{req: '{wr: 1'b0, addr: 4'd15, wdata: 8'h00}, stall: 2, exp: 8'h5A};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    after_reset();

    // Directed table, including write-then-read of the same address
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].req.wr, vecs[v].req.addr, vecs[v].req.wdata, w);
      if (!vecs[v].req.wr) recv(vecs[v].req.addr, vecs[v].exp, vecs[v].stall);
    end

    // Back-to-back writes: one per cycle, no stalls
    base = wr_pulses;
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, 4'(i), 8'(i * 17), w);
      chk("b2b_no_stall", 32'(w), 32'd0);
    end
    tick();
    chk("b2b_wr_pulses", 32'(wr_pulses - base), 32'(DEPTH));
    base = rd_pulses;
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 4'(i), 8'h00, w);
      recv(4'(i), 8'(i * 17), 0);
    end
    chk("sweep_rd_pulses", 32'(rd_pulses - base), 32'(DEPTH));

    // Randomized traffic against the reference memory
    for (int k = 0; k < 150; k++) begin
      a = 4'($urandom_range(0, DEPTH - 1));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        send(1'b1, a, d, w);
      end else begin
        send(1'b0, a, 8'h00, w);
        recv(a, ref_mem[a], $urandom_range(0, 3));
      end
    end

    // Reset while a read is outstanding
    send(1'b1, 4'd9, 8'hFF, w);
    send(1'b0, 4'd5, 8'h00, w);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midop_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    after_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    send(1'b0, 4'd9, 8'h00, w);
    recv(4'd9, ref_mem[9], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
